// File: rtl/signal_stats.sv
// ============================================================================
// Module   : signal_stats
// Brief    : Windowed DC mean / peak max / peak min / peak-to-peak over
//            non-overlapping windows of 2^LOG2_N accepted ADC samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_stats #(
  parameter int WIDTH  = 12,
  parameter int LOG2_N = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DATA_VALID,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] mean,
  output logic [WIDTH-1:0] vmax,
  output logic [WIDTH-1:0] vmin,
  output logic [WIDTH-1:0] vpp,
  output logic             UPDATE,
  output logic             STATS_VALID
);

  localparam int                ACC_W  = WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] C_LAST = '1;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [LOG2_N-1:0]  r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]   r_max;
  logic [WIDTH-1:0]   r_min;

  logic [ACC_W-1:0]   w_sum;
  logic [WIDTH-1:0]   w_nmax;
  logic [WIDTH-1:0]   w_nmin;
  logic               w_last;

  // Running statistics including the sample presented this cycle.
  always_comb begin
    w_sum  = r_acc + ACC_W'(DATA_IN);
    w_nmax = (DATA_IN > r_max) ? DATA_IN : r_max;
    w_nmin = (DATA_IN < r_min) ? DATA_IN : r_min;
    w_last = (r_cnt == C_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_max       <= '0;
      r_min       <= '1;
      mean        <= '0;
      vmax        <= '0;
      vmin        <= '0;
      vpp         <= '0;
      UPDATE      <= 1'b0;
      STATS_VALID <= 1'b0;
    end else begin
      UPDATE      <= 1'b0;
      STATS_VALID <= (r_state == S_RUN);
      if (CLEAR) begin
        // A sample arriving with CLEAR is dropped; published results stay.
        r_cnt <= '0;
        r_acc <= '0;
        r_max <= '0;
        r_min <= '1;
      end else if (DATA_VALID && !w_last) begin
        r_cnt <= r_cnt + LOG2_N'(1);
        r_acc <= w_sum;
        r_max <= w_nmax;
        r_min <= w_nmin;
      end else if (DATA_VALID) begin
        mean        <= w_sum[ACC_W-1:LOG2_N];
        vmax        <= w_nmax;
        vmin        <= w_nmin;
        vpp         <= w_nmax - w_nmin;
        UPDATE      <= 1'b1;
        STATS_VALID <= 1'b1;
        r_state     <= S_RUN;
        r_cnt       <= '0;
        r_acc       <= '0;
        r_max       <= '0;
        r_min       <= '1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signal_stats.sv
// ============================================================================
// Module   : tb_signal_stats
// Brief    : Directed bench for signal_stats with hand-computed window results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_stats;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] DATA_IN = '0;
  logic        DATA_VALID = 1'b0;
  logic        CLEAR = 1'b0;
  logic [11:0] mean, vmax, vmin, vpp;
  logic        UPDATE, STATS_VALID;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int upd_cyc = 0;
  int t1 = 0;

  signal_stats #(.WIDTH(12), .LOG2_N(10)) u_dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .CLEAR(CLEAR), .mean(mean), .vmax(vmax), .vmin(vmin), .vpp(vpp),
    .UPDATE(UPDATE), .STATS_VALID(STATS_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, observe 1 time unit later.
  task automatic step(input logic [11:0] d, input logic v, input logic clr, input logic rst);
    DATA_IN    = d;
    DATA_VALID = v;
    CLEAR      = clr;
    RST        = rst;
    @(posedge CLK);
    #1;
    cyc++;
    if (UPDATE === 1'b1) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
  endtask

  task automatic chk_out(input string tag, input int m, input int mx, input int mn, input int pp);
    chk({tag, ".mean"}, 32'(mean), 32'(m));
    chk({tag, ".vmax"}, 32'(vmax), 32'(mx));
    chk({tag, ".vmin"}, 32'(vmin), 32'(mn));
    chk({tag, ".vpp"},  32'(vpp),  32'(pp));
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.update", 32'(UPDATE), 0);
    chk("reset.valid", 32'(STATS_VALID), 0);

    // Constant 2048
    upd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      step(12'd2048, 1, 0, 0);
      if (i == 1022) chk("dc.valid_early", 32'(STATS_VALID), 0);
    end
    chk("dc.update", 32'(UPDATE), 1);
    chk("dc.upd_cnt", 32'(upd_cnt), 1);
    chk("dc.valid", 32'(STATS_VALID), 1);
    chk_out("dc", 2048, 2048, 2048, 0);

    // Ramp 0..1023 then full scale
    upd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      step(12'(i), 1, 0, 0);
      if (i == 0) chk("dc.pulse_width", 32'(UPDATE), 0);
    end
    chk("ramp.upd_cnt", 32'(upd_cnt), 1);
    chk_out("ramp", 511, 1023, 0, 1023);
    upd_cnt = 0;
    for (int i = 0; i < 1024; i++) step(12'd4095, 1, 0, 0);
    chk("fs.upd_cnt", 32'(upd_cnt), 1);
    chk_out("fs", 4095, 4095, 4095, 0);

    // Ramp with gaps in DATA_VALID
    upd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) begin
        step(12'd4000, 0, 0, 0);
        step(12'd5, 0, 0, 0);
      end
      step(12'(i), 1, 0, 0);
    end
    chk("gap.update", 32'(UPDATE), 1);
    chk("gap.upd_cnt", 32'(upd_cnt), 1);
    chk_out("gap", 511, 1023, 0, 1023);

    // Partial window discarded by CLEAR (sample on CLEAR edge dropped)
    upd_cnt = 0;
    for (int i = 0; i < 500; i++) step(12'd3000, 1, 0, 0);
    step(12'd3000, 1, 1, 0);
    chk("clr.upd_cnt", 32'(upd_cnt), 0);
    chk_out("clr.hold", 511, 1023, 0, 1023);
    for (int i = 0; i < 1023; i++) step(12'd100, 1, 0, 0);
    chk("clr.early", 32'(upd_cnt), 0);
    chk_out("clr.hold2", 511, 1023, 0, 1023);
    step(12'd100, 1, 0, 0);
    chk("clr.upd_cnt2", 32'(upd_cnt), 1);
    chk_out("clr", 100, 100, 100, 0);

    // CLEAR coincident with the last sample wins
    upd_cnt = 0;
    for (int i = 0; i < 1023; i++) step(12'd500, 1, 0, 0);
    step(12'd500, 1, 1, 0);
    chk("clrlast.update", 32'(UPDATE), 0);
    chk_out("clrlast.hold", 100, 100, 100, 0);
    for (int i = 0; i < 1024; i++) step(12'd600, 1, 0, 0);
    chk("clrlast.upd_cnt", 32'(upd_cnt), 1);
    chk_out("clrlast", 600, 600, 600, 0);

    // Reset mid-window
    for (int i = 0; i < 699; i++) step(12'd700, 1, 0, 0);
    step(12'd700, 1, 0, 1);
    chk_out("rstmid", 0, 0, 0, 0);
    chk("rstmid.valid", 32'(STATS_VALID), 0);
    upd_cnt = 0;
    for (int i = 0; i < 1023; i++) step(12'd1000, 1, 0, 0);
    chk("rstmid.early", 32'(upd_cnt), 0);
    chk("rstmid.valid2", 32'(STATS_VALID), 0);
    step(12'd1000, 1, 0, 0);
    chk("rstmid.upd_cnt", 32'(upd_cnt), 1);
    chk("rstmid.valid3", 32'(STATS_VALID), 1);
    chk_out("rstmid.win", 1000, 1000, 1000, 0);

    // Alternating 0/4095 for two back-to-back windows
    upd_cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      step((i % 2 == 0) ? 12'd0 : 12'd4095, 1, 0, 0);
      if (i == 1023) begin
        t1 = upd_cyc;
        chk("alt1.update", 32'(UPDATE), 1);
        chk_out("alt1", 2047, 4095, 0, 4095);
      end
    end
    chk("alt2.update", 32'(UPDATE), 1);
    chk_out("alt2", 2047, 4095, 0, 4095);
    chk("alt.upd_cnt", 32'(upd_cnt), 2);
    chk("alt.spacing", 32'(upd_cyc - t1), 1024);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
